// File: rtl/cos_series_engine.sv
// ---------------------------------------------------------------------------
// cos_series_engine
//
// Sequential cosine evaluator. It computes
//     cos(x) = 1 - x^2/2! + x^4/4! - ...
// with the term recurrence term_k = term_(k-1) * x^2 * coef_(k-1). The
// coefficients come from the external coefficient ROM, which this block
// addresses through rom_sel.
//
// ROM contents, all Q8.8:
//     sel 0..6 = 1/2, 1/12, 1/30, 1/56, 1/90, 1/132, 1/182
//     sel 7    = 1.0
//
// Parameters
//   N_TERMS  number of series terms, including the constant 1.0 (legal 2..8)
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   request; only looked at in IDLE
//   x         in   16  angle, unsigned Q8.8 radians, latched together with start
//   rom_coef  in   16  ROM coefficient, Q8.8; combinational on rom_sel
//   rom_sel   out  3   ROM address (registered)
//   busy      out  1   high whenever the engine is not IDLE
//   done      out  1   one-cycle pulse; result is valid during it
//   result    out  16  cos(x), signed Q8.8, registered; holds until the next run
//
// Build option
//   COS_ROUND_EN  when defined, every >>8 adds 128 first (round half up).
//                 Otherwise the shift is an arithmetic truncation toward -inf.
// ---------------------------------------------------------------------------
module cos_series_engine #(
    parameter int N_TERMS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [15:0] rom_coef,
    output logic [2:0]  rom_sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SQUARE,
        S_MUL_X2,
        S_MUL_COEF,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic [2:0]         K_LAST  = 3'(N_TERMS - 2);
    localparam logic signed [34:0] SAT_POS = 35'sd131071;
    localparam logic signed [34:0] SAT_NEG = -35'sd131071;

    state_t state, state_nxt;

    logic [15:0]        x_lat;
    logic [15:0]        x2;
    logic signed [17:0] term;
    logic signed [17:0] p;
    logic signed [17:0] sum;
    logic [2:0]         k;

    logic [31:0]        sq_u;
    logic signed [34:0] sq_sh;
    logic [15:0]        x2_nxt;
    logic signed [17:0] p_nxt;
    logic signed [17:0] term_nxt;
    logic signed [17:0] sum_nxt;

    // Sign-extend an 18-bit internal value to the 35-bit product width.
    function automatic logic signed [34:0] ext35(input logic signed [17:0] v);
        return {{17{v[17]}}, v};
    endfunction

    // Zero-extend an unsigned Q8.8 operand (x^2, ROM coefficient).
    function automatic logic signed [34:0] zext35(input logic [15:0] v);
        return {19'b0, v};
    endfunction

    // Drop the 8 extra fraction bits of a Q8.8 x Q8.8 product.
    function automatic logic signed [34:0] shr8(input logic signed [34:0] v);
`ifdef COS_ROUND_EN
        return (v + 35'sd128) >>> 8;
`else
        return v >>> 8;
`endif
    endfunction

    // Clamp to the symmetric 18-bit internal range +/-(2^17-1).
    function automatic logic signed [17:0] sat18(input logic signed [34:0] v);
        if (v > SAT_POS)
            return 18'sd131071;
        else if (v < SAT_NEG)
            return -18'sd131071;
        else
            return v[17:0];
    endfunction

    // Clamp the accumulator to the 16-bit signed output range.
    function automatic logic [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'h7FFF;
        else if (v < -18'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    // Datapath arithmetic for each state's update.
    always_comb begin
        sq_u     = 32'(x_lat) * 32'(x_lat);
        sq_sh    = shr8($signed({3'b000, sq_u}));
        x2_nxt   = (sq_sh > 35'sd65535) ? 16'hFFFF : sq_sh[15:0];
        p_nxt    = sat18(shr8(ext35(term) * zext35(x2)));
        term_nxt = sat18(shr8(ext35(p) * zext35(rom_coef)));
        // Even k subtracts: the k=0 term is -x^2/2!, then the signs alternate.
        sum_nxt  = k[0] ? sat18(ext35(sum) + ext35(term))
                        : sat18(ext35(sum) - ext35(term));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:     if (start) state_nxt = S_INIT;
            S_INIT:     state_nxt = S_SQUARE;
            S_SQUARE:   state_nxt = S_MUL_X2;
            S_MUL_X2:   state_nxt = S_MUL_COEF;
            S_MUL_COEF: state_nxt = S_ACC;
            S_ACC:      state_nxt = (k == K_LAST) ? S_DONE : S_MUL_X2;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // rom_sel is set on the edge that enters INIT / MUL_COEF, so the ROM output
    // has a full cycle to settle before that state consumes rom_coef.
    // result is loaded on the edge that enters DONE, so it is valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat   <= '0;
            x2      <= '0;
            term    <= '0;
            p       <= '0;
            sum     <= '0;
            k       <= '0;
            rom_sel <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_lat   <= x;
                        rom_sel <= 3'd7;
                    end
                end
                S_INIT: begin
                    term <= $signed({2'b00, rom_coef});
                    sum  <= $signed({2'b00, rom_coef});
                    k    <= '0;
                end
                S_SQUARE: x2 <= x2_nxt;
                S_MUL_X2: begin
                    p       <= p_nxt;
                    rom_sel <= k;
                end
                S_MUL_COEF: term <= term_nxt;
                S_ACC: begin
                    sum <= sum_nxt;
                    if (k == K_LAST)
                        result <= sat16(sum_nxt);
                    else
                        k <= k + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
